// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: lane count, selector width and lane-index encodings shared by mux_rr and demux
package mux_rr_pkg;
    localparam int NUM_CARRILES = 4;
    localparam int SEL_BITS     = 2;
    typedef enum logic [SEL_BITS-1:0] {
        CARRIL0 = 2'b00,
        CARRIL1 = 2'b01,
        CARRIL2 = 2'b10,
        CARRIL3 = 2'b11
    } carril_e;
endpackage

// File: rtl/mux_rr_if.sv
// mux_rr_if: lane FIFO heads, pop strobes and registered output stream of the egress mux
interface mux_rr_if #(parameter int DATA_BITS = 4);
    import mux_rr_pkg::*;
    logic                 enb;
    logic                 pausa;
    logic [DATA_BITS-1:0] entrada0, entrada1, entrada2, entrada3;
    logic                 vacio0, vacio1, vacio2, vacio3;
    logic                 pop0, pop1, pop2, pop3;
    logic [DATA_BITS-1:0] salida;
    logic                 valido;
    logic [SEL_BITS-1:0]  selector;
    modport master (
        input  enb, pausa, entrada0, entrada1, entrada2, entrada3, vacio0, vacio1, vacio2, vacio3,
        output pop0, pop1, pop2, pop3, salida, valido, selector
    );
    modport slave (
        output enb, pausa, entrada0, entrada1, entrada2, entrada3, vacio0, vacio1, vacio2, vacio3,
        input  pop0, pop1, pop2, pop3, salida, valido, selector
    );
endinterface

// File: rtl/mux_rr_arbitro_rr.sv
// arbitro_rr: combinational lane arbiter, round-robin from ptr or fixed lane-0-first under MUX_PRIORIDAD_FIJA_EN
module arbitro_rr
    import mux_rr_pkg::*;
(
    input  logic [NUM_CARRILES-1:0] req,
    input  logic [SEL_BITS-1:0]     ptr,
    output logic [NUM_CARRILES-1:0] gnt,
    output logic [SEL_BITS-1:0]     idx
);
    logic [SEL_BITS-1:0] k;
    logic                found;
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_CARRILES; i++) begin
`ifdef MUX_PRIORIDAD_FIJA_EN
            k = i[SEL_BITS-1:0];
`else
            k = ptr + i[SEL_BITS-1:0];
`endif
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                idx    = k;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_rr.sv
// mux_rr: 4-to-1 FWFT lane recombiner with registered output; MUX_PRIORIDAD_FIJA_EN selects fixed priority
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int DATA_BITS = 4
) (
    input  logic      clk,
    input  logic      reset,
    mux_rr_if.master  bus
);
    logic [NUM_CARRILES-1:0] req, gnt, pop;
    logic [SEL_BITS-1:0]     idx, ptr;
    logic [DATA_BITS-1:0]    dato;
    logic                    libre;

    assign req   = ~{bus.vacio3, bus.vacio2, bus.vacio1, bus.vacio0};
    assign libre = bus.enb & ~bus.pausa & ~reset;
    assign pop   = gnt & {NUM_CARRILES{libre}};
    assign {bus.pop3, bus.pop2, bus.pop1, bus.pop0} = pop;

    arbitro_rr u_arb (.req(req), .ptr(ptr), .gnt(gnt), .idx(idx));

    always_comb
        dato = idx == CARRIL0 ? bus.entrada0 :
               idx == CARRIL1 ? bus.entrada1 :
               idx == CARRIL2 ? bus.entrada2 : bus.entrada3;

`ifdef MUX_PRIORIDAD_FIJA_EN
    assign ptr = '0;
`else
    // Pointer moves just past the served lane so it becomes lowest priority next.
    always_ff @(posedge clk)
        if (reset)
            ptr <= '0;
        else if (|pop)
            ptr <= idx + 2'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.salida   <= '0;
            bus.valido   <= 1'b0;
            bus.selector <= '0;
        end else if (|pop) begin
            bus.salida   <= dato;
            bus.valido   <= 1'b1;
            bus.selector <= idx;
        end else begin
            bus.salida   <= '0;
            bus.valido   <= 1'b0;
        end
    end
endmodule
